// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// Module : game_pkg
// Brief  : Shared game-flow state encoding and PS/2 ASCII key codes.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package game_pkg;

    typedef enum logic [2:0] {
        MENU  = 3'd0,
        PLAY  = 3'd1,
        PAUSE = 3'd2,
        DEAD  = 3'd3,
        OVER  = 3'd4,
        WIN   = 3'd5
    } game_state_t;

    localparam logic [6:0] KEY_ENTER = 7'h0D;
    localparam logic [6:0] KEY_P     = 7'h70;
    localparam logic [6:0] KEY_A     = 7'h61;
    localparam logic [6:0] KEY_D     = 7'h64;
    localparam logic [6:0] KEY_W     = 7'h77;

endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
// ---------------------------------------------------------------------------
// Module : frame_timer
// Brief  : Frame-pulse down-counter with load, enable and expiry strobe.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module frame_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             tick,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Asserted in the cycle whose edge takes the count from 1 to 0, so the
    // consumer's registered reaction lands on the cycle after the tick.
    assign done = en && tick && !load && (r_count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// Module : game_ctrl
// Brief  : Game-flow FSM, key-to-movement translation and lives counter.
//          Optional PAUSE state enabled by defining GAME_CTRL_PAUSE_EN.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 120,
    parameter int HOLD_FRAMES    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] ascii_code,
    input  logic       ascii_new,
    input  logic       frame_start,
    input  logic       hit,
    input  logic       goal,
    output logic [2:0] state,
    output logic       play_en,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       respawn,
    output logic [1:0] lives
);

    localparam int c_HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int c_DEAD_W = $clog2(RESPAWN_FRAMES + 1);

    game_state_t r_state, w_next_state;
    logic [1:0]  r_lives, w_lives_next;
    logic        r_play_en, w_play_en_next;
    logic        r_move_left, w_move_left_next;
    logic        r_move_right, w_move_right_next;
    logic        r_jump, w_jump_next;
    logic        r_respawn, w_respawn_next;

    logic w_key_enter, w_key_p, w_key_a, w_key_d, w_key_w;
    logic w_stay_play, w_leave_play;
    logic w_left_set, w_right_set;
    logic w_left_load, w_right_load, w_dead_load;
    logic w_left_done, w_right_done, w_dead_done;
    logic [c_HOLD_W-1:0] w_left_val, w_right_val;

    assign w_key_enter = ascii_new && (ascii_code == KEY_ENTER);
    assign w_key_a     = ascii_new && (ascii_code == KEY_A);
    assign w_key_d     = ascii_new && (ascii_code == KEY_D);
    assign w_key_w     = ascii_new && (ascii_code == KEY_W);
`ifdef GAME_CTRL_PAUSE_EN
    assign w_key_p     = ascii_new && (ascii_code == KEY_P);
`else
    assign w_key_p     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= MENU;
            r_lives      <= 2'd0;
            r_play_en    <= 1'b0;
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_jump       <= 1'b0;
            r_respawn    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_lives      <= w_lives_next;
            r_play_en    <= w_play_en_next;
            r_move_left  <= w_move_left_next;
            r_move_right <= w_move_right_next;
            r_jump       <= w_jump_next;
            r_respawn    <= w_respawn_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            MENU:  if (w_key_enter) w_next_state = PLAY;
            PLAY: begin
                if (hit)          w_next_state = DEAD;
                else if (goal)    w_next_state = WIN;
                else if (w_key_p) w_next_state = PAUSE;
            end
            PAUSE: if (w_key_p) w_next_state = PLAY;
            DEAD: begin
                if (w_dead_done) w_next_state = (r_lives == 2'd0) ? OVER : PLAY;
            end
            OVER:  if (w_key_enter) w_next_state = MENU;
            WIN:   if (w_key_enter) w_next_state = MENU;
            default: w_next_state = MENU;
        endcase
    end

    // Pausing keeps the movement commands and hold counters intact; every
    // other exit from PLAY wipes them.
    assign w_stay_play  = (r_state == PLAY) && (w_next_state == PLAY);
    assign w_leave_play = (r_state == PLAY) && (w_next_state != PLAY)
                          && (w_next_state != PAUSE);
    assign w_left_set   = w_stay_play && w_key_a;
    assign w_right_set  = w_stay_play && w_key_d;

    always_comb begin
        w_lives_next = r_lives;
        if ((r_state == MENU) && w_key_enter) begin
            w_lives_next = 2'(LIVES);
        end else if ((r_state == PLAY) && hit) begin
            w_lives_next = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
        end

        w_move_left_next = r_move_left;
        if (w_leave_play || w_right_set || w_left_done) w_move_left_next = 1'b0;
        if (w_left_set)                                 w_move_left_next = 1'b1;

        w_move_right_next = r_move_right;
        if (w_leave_play || w_left_set || w_right_done) w_move_right_next = 1'b0;
        if (w_right_set)                                w_move_right_next = 1'b1;

        w_play_en_next = (w_next_state == PLAY);
        w_jump_next    = w_stay_play && w_key_w;
        w_respawn_next = (w_next_state == PLAY)
                         && ((r_state == MENU) || (r_state == DEAD));
    end

    assign w_left_load  = w_left_set || w_right_set || w_leave_play;
    assign w_left_val   = w_left_set ? c_HOLD_W'(HOLD_FRAMES) : '0;
    assign w_right_load = w_left_set || w_right_set || w_leave_play;
    assign w_right_val  = w_right_set ? c_HOLD_W'(HOLD_FRAMES) : '0;
    assign w_dead_load  = (r_state == PLAY) && hit;

    frame_timer #(.WIDTH(c_HOLD_W)) u_left_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (w_left_load),
        .load_val (w_left_val),
        .en       (r_state == PLAY),
        .tick     (frame_start),
        .done     (w_left_done)
    );

    frame_timer #(.WIDTH(c_HOLD_W)) u_right_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (w_right_load),
        .load_val (w_right_val),
        .en       (r_state == PLAY),
        .tick     (frame_start),
        .done     (w_right_done)
    );

    frame_timer #(.WIDTH(c_DEAD_W)) u_dead_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (w_dead_load),
        .load_val (c_DEAD_W'(RESPAWN_FRAMES)),
        .en       (r_state == DEAD),
        .tick     (frame_start),
        .done     (w_dead_done)
    );

    assign state      = r_state;
    assign lives      = r_lives;
    assign play_en    = r_play_en;
    assign move_left  = r_move_left;
    assign move_right = r_move_right;
    assign jump       = r_jump;
    assign respawn    = r_respawn;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// Module : tb_game_ctrl
// Brief  : Directed self-checking bench for game_ctrl (default parameters).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_game_ctrl;

    localparam logic [2:0] S_MENU = 3'd0, S_PLAY = 3'd1, S_PAUSE = 3'd2,
                           S_DEAD = 3'd3, S_OVER = 3'd4, S_WIN = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] ascii_code = 7'h00;
    logic       ascii_new = 1'b0;
    logic       frame_start = 1'b0;
    logic       hit = 1'b0;
    logic       goal = 1'b0;
    logic [2:0] state;
    logic       play_en, move_left, move_right, jump, respawn;
    logic [1:0] lives;

    int tests = 0;
    int fails = 0;

    game_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ascii_code  (ascii_code),
        .ascii_new   (ascii_new),
        .frame_start (frame_start),
        .hit         (hit),
        .goal        (goal),
        .state       (state),
        .play_en     (play_en),
        .move_left   (move_left),
        .move_right  (move_right),
        .jump        (jump),
        .respawn     (respawn),
        .lives       (lives)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [6:0] code);
        ascii_code = code;
        ascii_new  = 1'b1;
        step();
        ascii_new  = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        tests++;
        if (state !== S_MENU || lives !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: state=%0d lives=%0d, want 0/0", state, lives);
        end
        tests++;
        if ({play_en, move_left, move_right, jump, respawn} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, want 00000",
                     {play_en, move_left, move_right, jump, respawn});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_start();
        key(7'h0D);
        tests++;
        if (state !== S_PLAY || lives !== 2'd3 || respawn !== 1'b1 || play_en !== 1'b1) begin
            fails++;
            $display("FAIL start: state=%0d lives=%0d respawn=%b play_en=%b, want 1/3/1/1",
                     state, lives, respawn, play_en);
        end
        step();
        tests++;
        if (respawn !== 1'b0) begin
            fails++;
            $display("FAIL start_respawn_pulse: respawn=%b, want 0", respawn);
        end
    endtask

    task automatic test_hold();
        key(7'h64);
        tests++;
        if (move_right !== 1'b1 || move_left !== 1'b0) begin
            fails++;
            $display("FAIL press_d: right=%b left=%b, want 1/0", move_right, move_left);
        end
        for (int i = 1; i <= 8; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            tests++;
            if (move_right !== (i < 8)) begin
                fails++;
                $display("FAIL hold_d frame %0d: right=%b, want %b", i, move_right, i < 8);
            end
            step();
        end
        key(7'h64);
        frames(3);
        key(7'h61);
        tests++;
        if (move_right !== 1'b0 || move_left !== 1'b1) begin
            fails++;
            $display("FAIL a_mid_hold: right=%b left=%b, want 0/1", move_right, move_left);
        end
        frames(3);
        // A coinciding with a frame pulse reloads the full hold
        ascii_code = 7'h61;
        ascii_new = 1'b1;
        frame_start = 1'b1;
        step();
        ascii_new = 1'b0;
        frame_start = 1'b0;
        step();
        frames(7);
        tests++;
        if (move_left !== 1'b1) begin
            fails++;
            $display("FAIL reload_wins: left=%b after 7 frames, want 1", move_left);
        end
        frames(1);
        tests++;
        if (move_left !== 1'b0) begin
            fails++;
            $display("FAIL reload_expire: left=%b after 8 frames, want 0", move_left);
        end
    endtask

    task automatic test_jump_and_ignored();
        key(7'h77);
        tests++;
        if (jump !== 1'b1) begin
            fails++;
            $display("FAIL jump: jump=%b, want 1", jump);
        end
        step();
        tests++;
        if (jump !== 1'b0) begin
            fails++;
            $display("FAIL jump_pulse: jump=%b, want 0", jump);
        end
        key(7'h78);
        tests++;
        if (state !== S_PLAY || {move_left, move_right, jump} !== 3'b0) begin
            fails++;
            $display("FAIL ignored_key: state=%0d cmds=%b, want 1/000",
                     state, {move_left, move_right, jump});
        end
    endtask

    task automatic test_pause();
`ifdef GAME_CTRL_PAUSE_EN
        key(7'h61);
        frames(3);
        key(7'h70);
        tests++;
        if (state !== S_PAUSE || play_en !== 1'b0 || move_left !== 1'b1) begin
            fails++;
            $display("FAIL pause_enter: state=%0d play_en=%b left=%b, want 2/0/1",
                     state, play_en, move_left);
        end
        frames(10);
        key(7'h70);
        tests++;
        if (state !== S_PLAY || move_left !== 1'b1) begin
            fails++;
            $display("FAIL pause_exit: state=%0d left=%b, want 1/1", state, move_left);
        end
        for (int i = 1; i <= 5; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            tests++;
            if (move_left !== (i < 5)) begin
                fails++;
                $display("FAIL pause_remaining frame %0d: left=%b, want %b", i, move_left, i < 5);
            end
            step();
        end
`else
        key(7'h70);
        tests++;
        if (state !== S_PLAY || play_en !== 1'b1) begin
            fails++;
            $display("FAIL p_ignored: state=%0d play_en=%b, want 1/1", state, play_en);
        end
`endif
    endtask

    task automatic test_hit_goal_and_over();
        key(7'h64);
        hit = 1'b1;
        goal = 1'b1;
        step();
        hit = 1'b0;
        goal = 1'b0;
        tests++;
        if (state !== S_DEAD || lives !== 2'd2 || move_right !== 1'b0 || play_en !== 1'b0) begin
            fails++;
            $display("FAIL hit_and_goal: state=%0d lives=%0d right=%b play_en=%b, want 3/2/0/0",
                     state, lives, move_right, play_en);
        end
        for (int d = 0; d < 2; d++) begin
            frames(119);
            tests++;
            if (state !== S_DEAD) begin
                fails++;
                $display("FAIL dead_hold %0d: state=%0d, want 3", d, state);
            end
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            tests++;
            if (state !== S_PLAY || respawn !== 1'b1) begin
                fails++;
                $display("FAIL respawn %0d: state=%0d respawn=%b, want 1/1", d, state, respawn);
            end
            step();
            hit = 1'b1;
            step();
            hit = 1'b0;
            tests++;
            if (state !== S_DEAD || lives !== 2'(1 - d)) begin
                fails++;
                $display("FAIL hit %0d: state=%0d lives=%0d, want 3/%0d", d, state, lives, 1 - d);
            end
        end
        frames(120);
        tests++;
        if (state !== S_OVER || lives !== 2'd0 || respawn !== 1'b0) begin
            fails++;
            $display("FAIL game_over: state=%0d lives=%0d respawn=%b, want 4/0/0",
                     state, lives, respawn);
        end
        hit = 1'b1;
        step();
        hit = 1'b0;
        tests++;
        if (state !== S_OVER || lives !== 2'd0) begin
            fails++;
            $display("FAIL hit_in_over: state=%0d lives=%0d, want 4/0", state, lives);
        end
        key(7'h0D);
        tests++;
        if (state !== S_MENU) begin
            fails++;
            $display("FAIL over_to_menu: state=%0d, want 0", state);
        end
    endtask

    task automatic test_win();
        key(7'h0D);
        step();
        goal = 1'b1;
        step();
        goal = 1'b0;
        tests++;
        if (state !== S_WIN || lives !== 2'd3 || play_en !== 1'b0) begin
            fails++;
            $display("FAIL win: state=%0d lives=%0d play_en=%b, want 5/3/0", state, lives, play_en);
        end
        key(7'h0D);
        tests++;
        if (state !== S_MENU) begin
            fails++;
            $display("FAIL win_to_menu: state=%0d, want 0", state);
        end
    endtask

    task automatic test_reset_mid_dead();
        logic saw_pulse;
        key(7'h0D);
        step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        frames(60);
        rst = 1'b0;
        step();
        rst = 1'b1;
        tests++;
        if (state !== S_MENU || lives !== 2'd0
            || {play_en, move_left, move_right, jump, respawn} !== 5'b0) begin
            fails++;
            $display("FAIL reset_mid_dead: state=%0d lives=%0d outs=%b, want 0/0/00000",
                     state, lives, {play_en, move_left, move_right, jump, respawn});
        end
        saw_pulse = 1'b0;
        for (int i = 0; i < 130; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            if (respawn === 1'b1 || state !== S_MENU) saw_pulse = 1'b1;
            step();
            if (respawn === 1'b1 || state !== S_MENU) saw_pulse = 1'b1;
        end
        tests++;
        if (saw_pulse !== 1'b0) begin
            fails++;
            $display("FAIL no_late_respawn: late activity=%b, want 0", saw_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hold();
        test_jump_and_ignored();
        test_pause();
        test_hit_goal_and_over();
        test_win();
        test_reset_mid_dead();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/game_ctrl.md
# game_ctrl

Game-flow controller sitting between the PS/2 ASCII decoder and the movement/draw datapath. It sequences menu → play → death/respawn → game-over/win, translates key events into registered movement commands, and owns the lives counter. It also gates the movement datapath: frozen outside PLAY, and re-spawned on death. All logic runs in the 40 MHz pixel domain; key events arrive already synchronized to `clk`.

## Interface
- `LIVES`, default 3: lives at game start, 1..3.
- `RESPAWN_FRAMES`, default 120: frames spent in DEAD before respawn.
- `HOLD_FRAMES`, default 8: frames a left/right command stays asserted after the last matching key event.
- `clk` input 1: 40 MHz pixel clock.
- `rst` input 1: synchronous, active-low reset.
- `ascii_code` input 7: decoded key, valid when `ascii_new`=1.
- `ascii_new` input 1: 1-cycle key-event strobe.
- `frame_start` input 1: 1-cycle pulse per frame, start of vertical blanking.
- `hit` input 1: player/hazard collision, level-sampled.
- `goal` input 1: player reached goal, level-sampled.
- `state` output 3: current `game_state_t`.
- `play_en` output 1: movement datapath enable.
- `move_left` output 1: walk-left command, held.
- `move_right` output 1: walk-right command, held.
- `jump` output 1: 1-cycle jump pulse.
- `respawn` output 1: 1-cycle pulse; movement reloads its start position.
- `lives` output 2: remaining lives.

## Operation
- States: MENU, PLAY, PAUSE, DEAD, OVER, WIN.
- Key codes:
  - ENTER 0x0D; P 0x70 for pause.
  - A 0x61 left; D 0x64 right; W 0x77 jump.
  - All other codes are ignored.
- MENU:
  - ENTER → PLAY, `lives`←LIVES, `respawn` pulse.
- PLAY:
  - `hit`=1 → DEAD, `lives`−1.
  - `goal`=1 (and not `hit`) → WIN.
  - P → PAUSE.
- DEAD:
  - Counts `frame_start` pulses.
  - At RESPAWN_FRAMES: if `lives`=0 → OVER; else → PLAY with `respawn` pulse.
- PAUSE: P → PLAY. Hold timers and the DEAD counter are frozen.
- OVER/WIN: ENTER → MENU.
- `play_en`=1 only in PLAY.
- A/D in PLAY:
  - Sets the matching command and reloads its hold counter to HOLD_FRAMES.
  - Clears the opposite command.
  - Each `frame_start` decrements the active counter; the command drops when it reaches 0.
- W in PLAY: `jump` pulse.
- Leaving PLAY clears `move_left`, `move_right` and both hold counters.
- `lives` saturates at 0. `hit` in any state other than PLAY is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=MENU, `lives`=0.
  - `play_en`, `move_left`, `move_right`, `jump`, `respawn` all 0.
  - All counters 0.
- Latency:
  - `ascii_new` at cycle t → state/command change visible at t+1.
  - `hit`/`goal` sampled at t → DEAD/WIN at t+1.
- Same cycle `hit`+`goal` → DEAD (hit wins).
- `frame_start` coinciding with an A/D event: the reload wins over the decrement.
- Terminal DEAD frame:
  - Transition happens on the cycle after the RESPAWN_FRAMES-th `frame_start`.
  - `respawn` is asserted in the same cycle `state` becomes PLAY.
- Only one key is processed per `ascii_new`. Typematic repeats re-arm the hold counter.
- `rst` low mid-game → full reset on the next edge, with no trailing pulses.

## Configuration
- `GAME_CTRL_PAUSE_EN` defined: PAUSE state and the P key as described.
- Not defined:
  - PAUSE is unreachable.
  - P is ignored.
  - The state encoding is unchanged, so `state` width and values are identical.

## Structure
- `game_pkg` holds:
  - `typedef enum logic [2:0] game_state_t` (MENU=0, PLAY=1, PAUSE=2, DEAD=3, OVER=4, WIN=5).
  - Key-code localparams (KEY_ENTER, KEY_P, KEY_A, KEY_D, KEY_W).
- Sub-module `frame_timer`:
  - Frame-pulse down-counter with load, enable and `done` output.
  - Instantiated three times: left hold, right hold, DEAD delay.

## Test plan
- Reset then ENTER → `state`=PLAY, `lives`=3 and `respawn` pulse at t+1.
- In PLAY, press D once:
  - `move_right`=1 for exactly 8 `frame_start` pulses, then 0.
  - Press A mid-hold → `move_right`=0 and `move_left`=1 on the next cycle.
- Three `hit` pulses, each followed by 120 frames → after the third, DEAD→OVER with `lives`=0. ENTER → MENU.
- `hit` and `goal` asserted on the same cycle in PLAY → DEAD with `lives`=2, never WIN.
- With PAUSE_EN: P during DEAD-free PLAY with `move_left` active for 3 frames:
  - 10 frames pass with the hold frozen.
  - P again → `move_left` stays high for the remaining 5 frames.
  - Without the macro: P has no effect.
- `rst` low for 1 cycle mid-DEAD → all outputs are at reset values on the next cycle, and there is no later `respawn` pulse.
